fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage: owns PC, drives sync instruction memory, holds fetched instr in IF slot.
//  Exposes IF decode fields (rs1/rs2/opcode) to the stall unit; consumes data_stall/control_stall.
//  Issues instrs into the IF/RR pipeline register feeding register-read; inserts bubbles on stall.
//  Redirected by branch/jump resolution from the ALU stage.
// PARAMETERS
//  XLEN      32          data/PC width
//  RESET_PC  32'h0       PC after reset
//  NOP_INSTR 32'h00000013 bubble encoding (addi x0,x0,0)
// PORTS
//  clk              in  1     clock, all state rising-edge
//  rst_n            in  1     synchronous reset, active-low
//  imem_req         out 1     read request this cycle
//  imem_addr        out XLEN  read address (word aligned)
//  imem_rdata       in  32    instr, valid exactly 1 cycle after imem_req
//  data_stall       in  1     IF instr has RAW hazard; hold it
//  control_stall    in  1     RR holds branch/jump; hold IF, stop fetching
//  redirect_valid   in  1     ALU resolved branch/jump this cycle
//  redirect_taken   in  1     1: jump to redirect_target; 0: fall through
//  redirect_target  in  XLEN  taken target
//  if_rs1/if_rs2    out 5     IF slot instr[19:15]/[24:20]; 0 when slot empty
//  if_opcode        out 7     IF slot instr[6:0]; NOP opcode when slot empty
//  rr_valid         out 1     IF/RR register holds real instr
//  rr_pc            out XLEN  PC of rr_instr
//  rr_instr         out 32    instr to register-read; NOP_INSTR when !rr_valid
// BEHAVIOUR
//  Reset (rst_n=0 at edge): pc=RESET_PC, state=FETCH, slot empty, inflight=0, kill=0,
//   rr_valid=0, rr_instr=NOP_INSTR, rr_pc=0; imem_req=0 during reset cycle.
//  States: FETCH, WAIT_BR. issue = slot_valid & !data_stall & !control_stall & state==FETCH.
//  imem_req = state==FETCH & !control_stall & (!slot_valid | issue) & !redirect_valid; imem_addr=pc.
//   On req: pc<=pc+4 (mod 2^XLEN, wraps silently), inflight<=1.
//  Response (inflight at edge): if kill, drop and clear kill; else slot<={pc_of_req,imem_rdata}.
//   At most one request outstanding; slot never overwritten while valid and not issuing.
//  Issue: rr_*<=slot, slot_valid<=0 unless refilled same edge. No issue: rr_valid<=0, rr_instr<=NOP.
//  control_stall=1 in FETCH -> WAIT_BR next cycle; no new reqs; slot held (speculative).
//  WAIT_BR: bubbles to RR; exit only on redirect_valid.
//  redirect_valid (any state, priority over all stall inputs):
//   taken: pc<={redirect_target[XLEN-1:2],2'b00}; slot_valid<=0; kill<=inflight; state<=FETCH.
//   not taken: slot and pc kept; state<=FETCH.
//  Redirect and data_stall same cycle: redirect wins; no issue that cycle.
//  Latency: req at t -> slot at t+1 -> rr_* at t+2 (no stalls). Throughput 1 instr/cycle.
//  data_stall only freezes issue/fetch; it never changes pc or state.
// STRUCTURE
//  Shared header (codes): opcode macros (JAL, JALR, BRANCH, LUI, AUIPC, STORE), ZERO_REG, NOP_INSTR.
//  State encoding localparams local to this module.
//  One sub-module: if_rr_reg (IF/RR pipeline register with load/bubble controls).
//  fetch_stage keeps PC, FSM, inflight/kill tracking, IF slot.
// TESTING
//  1 Reset, imem returns addr-as-instr, no stalls -> rr_pc 0,4,8,... one per cycle from cycle 2.
//  2 data_stall high 3 cycles with slot pc=0x8 -> 3 bubbles (NOP), pc frozen, then rr_pc=0x8.
//  3 control_stall pulse then redirect taken target 0x103 -> slot dropped, next imem_addr=0x100.
//  4 control_stall then redirect not-taken -> held slot instr issues next, pc continues sequentially.
//  5 redirect taken with request in flight -> response dropped, first rr_pc is target.
//  6 rst_n low mid-WAIT_BR with slot valid -> all outputs at reset values next cycle, fetch from RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared encodings for the front end: base opcodes that later stages decode,
// the architectural zero register, the bubble instruction, and small helpers
// that pull decode fields out of a 32-bit instruction word.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;

  localparam logic [4:0]  ZERO_REG   = 5'd0;

  // addi x0,x0,0 : architecturally a no-op, used as the pipeline bubble
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  function automatic logic [4:0] rs1_of(input logic [31:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] instr);
    return instr[24:20];
  endfunction

  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/fetch_stage_if_rr_reg.sv
// -----------------------------------------------------------------------------
// fetch_stage_if_rr_reg
// IF/RR pipeline register. Loads a fetched instruction when the fetch stage
// issues, otherwise presents a bubble (valid low, NOP encoding).
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   i_load            capture i_pc/i_instr this edge
//   i_bubble          insert a bubble this edge (ignored when i_load is set)
//   i_pc, i_instr     instruction coming out of the IF slot
//   o_valid           register holds a real instruction
//   o_pc, o_instr     registered PC / instruction (NOP when !o_valid)
// -----------------------------------------------------------------------------
module fetch_stage_if_rr_reg
  import fetch_stage_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter logic [31:0] BUBBLE    = fetch_stage_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_bubble,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_instr,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [31:0]     o_instr
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;

  // Pipeline register: load beats bubble; pc is left alone on a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= {XLEN{1'b0}};
      r_instr <= BUBBLE;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end else if (i_bubble) begin
      r_valid <= 1'b0;
      r_instr <= BUBBLE;
    end else begin
      r_valid <= r_valid;
      r_pc    <= r_pc;
      r_instr <= r_instr;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch: owns the PC, drives a synchronous instruction memory
// (data returns the cycle after the request), holds the fetched instruction
// in the IF slot, and issues it into the IF/RR register unless stalled.
// Taken branches/jumps from the ALU redirect the PC and flush the front end.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   imem_req/imem_addr            memory read request and word address
//   imem_rdata                    instruction, valid the cycle after imem_req
//   data_stall                    RAW hazard on the IF instruction: hold it
//   control_stall                 RR holds a branch/jump: hold, stop fetching
//   redirect_valid/_taken/_target branch/jump resolution from the ALU
//   if_rs1/if_rs2/if_opcode       IF slot decode fields for the stall unit
//   rr_valid/rr_pc/rr_instr       IF/RR register contents
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int             XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter logic [31:0]    NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            data_stall,
  input  logic            control_stall,
  input  logic            redirect_valid,
  input  logic            redirect_taken,
  input  logic [XLEN-1:0] redirect_target,
  output logic [4:0]      if_rs1,
  output logic [4:0]      if_rs2,
  output logic [6:0]      if_opcode,
  output logic            rr_valid,
  output logic [XLEN-1:0] rr_pc,
  output logic [31:0]     rr_instr
);

  typedef enum logic [0:0] {
    ST_FETCH   = 1'b0,
    ST_WAIT_BR = 1'b1
  } state_e;

  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

  state_e          r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic            r_inflight;
  logic [XLEN-1:0] r_req_pc;

  // IF slot plus a one-entry catch buffer. A request made while the slot was
  // empty can return just as the slot fills and then stalls; the buffer keeps
  // that response so the slot is never overwritten and the PC need not rewind.
  logic            r_slot_valid, w_slot_valid_nxt;
  logic [XLEN-1:0] r_slot_pc,    w_slot_pc_nxt;
  logic [31:0]     r_slot_instr, w_slot_instr_nxt;
  logic            r_buf_valid,  w_buf_valid_nxt;
  logic [XLEN-1:0] r_buf_pc,     w_buf_pc_nxt;
  logic [31:0]     r_buf_instr,  w_buf_instr_nxt;

  logic w_in_fetch;
  logic w_issue;
  logic w_req;
  logic w_flush;
  logic w_unused;

  assign w_in_fetch = (r_state == ST_FETCH);
  // A redirect owns the cycle: nothing issues or fetches alongside it.
  assign w_issue = r_slot_valid & ~data_stall & ~control_stall & w_in_fetch & ~redirect_valid;
  assign w_req   = rst_n & w_in_fetch & ~control_stall & (~r_slot_valid | w_issue) & ~redirect_valid;
  assign w_flush = redirect_valid & redirect_taken;

  // Target low bits are dropped to keep fetches word aligned.
  assign w_unused = ^redirect_target[1:0];

  // Next-state logic: redirect always returns to FETCH; control_stall parks in WAIT_BR.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FETCH: begin
        if (redirect_valid) begin
          w_state_nxt = ST_FETCH;
        end else if (control_stall) begin
          w_state_nxt = ST_WAIT_BR;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_WAIT_BR: begin
        if (redirect_valid) begin
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_WAIT_BR;
        end
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  // Slot/buffer update. A response is present whenever a request was made
  // last cycle; on a taken redirect it is on the wrong path and is discarded.
  always_comb begin
    w_slot_valid_nxt = r_slot_valid;
    w_slot_pc_nxt    = r_slot_pc;
    w_slot_instr_nxt = r_slot_instr;
    w_buf_valid_nxt  = r_buf_valid;
    w_buf_pc_nxt     = r_buf_pc;
    w_buf_instr_nxt  = r_buf_instr;
    if (w_flush) begin
      w_slot_valid_nxt = 1'b0;
      w_buf_valid_nxt  = 1'b0;
    end else if (w_issue) begin
      if (r_buf_valid) begin
        w_slot_valid_nxt = 1'b1;
        w_slot_pc_nxt    = r_buf_pc;
        w_slot_instr_nxt = r_buf_instr;
        w_buf_valid_nxt  = r_inflight;
        w_buf_pc_nxt     = r_req_pc;
        w_buf_instr_nxt  = imem_rdata;
      end else if (r_inflight) begin
        w_slot_valid_nxt = 1'b1;
        w_slot_pc_nxt    = r_req_pc;
        w_slot_instr_nxt = imem_rdata;
      end else begin
        w_slot_valid_nxt = 1'b0;
      end
    end else if (r_inflight) begin
      if (r_slot_valid) begin
        w_buf_valid_nxt  = 1'b1;
        w_buf_pc_nxt     = r_req_pc;
        w_buf_instr_nxt  = imem_rdata;
      end else begin
        w_slot_valid_nxt = 1'b1;
        w_slot_pc_nxt    = r_req_pc;
        w_slot_instr_nxt = imem_rdata;
      end
    end else begin
      w_slot_valid_nxt = r_slot_valid;
    end
  end

  // State, PC, request tracking and IF slot registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_FETCH;
      r_pc         <= RESET_PC;
      r_inflight   <= 1'b0;
      r_req_pc     <= {XLEN{1'b0}};
      r_slot_valid <= 1'b0;
      r_slot_pc    <= {XLEN{1'b0}};
      r_slot_instr <= NOP_INSTR;
      r_buf_valid  <= 1'b0;
      r_buf_pc     <= {XLEN{1'b0}};
      r_buf_instr  <= NOP_INSTR;
    end else begin
      r_state      <= w_state_nxt;
      r_inflight   <= w_req;
      r_slot_valid <= w_slot_valid_nxt;
      r_slot_pc    <= w_slot_pc_nxt;
      r_slot_instr <= w_slot_instr_nxt;
      r_buf_valid  <= w_buf_valid_nxt;
      r_buf_pc     <= w_buf_pc_nxt;
      r_buf_instr  <= w_buf_instr_nxt;
      if (w_req) begin
        r_req_pc <= r_pc;
      end else begin
        r_req_pc <= r_req_pc;
      end
      if (w_flush) begin
        r_pc <= {redirect_target[XLEN-1:2], 2'b00};
      end else if (w_req) begin
        r_pc <= r_pc + PC_STEP;
      end else begin
        r_pc <= r_pc;
      end
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = r_pc;

  assign if_rs1    = r_slot_valid ? rs1_of(r_slot_instr)    : ZERO_REG;
  assign if_rs2    = r_slot_valid ? rs2_of(r_slot_instr)    : ZERO_REG;
  assign if_opcode = r_slot_valid ? opcode_of(r_slot_instr) : NOP_INSTR[6:0];

  fetch_stage_if_rr_reg #(
    .XLEN   (XLEN),
    .BUBBLE (NOP_INSTR)
  ) u_if_rr_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_issue),
    .i_bubble (~w_issue),
    .i_pc     (r_slot_pc),
    .i_instr  (r_slot_instr),
    .o_valid  (rr_valid),
    .o_pc     (rr_pc),
    .o_instr  (rr_instr)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. The instruction memory returns the request
// address as the instruction word, one cycle after the request. Inputs change
// 1 time unit after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        data_stall;
  logic        control_stall;
  logic        redirect_valid;
  logic        redirect_taken;
  logic [31:0] redirect_target;
  logic [4:0]  if_rs1;
  logic [4:0]  if_rs2;
  logic [6:0]  if_opcode;
  logic        rr_valid;
  logic [31:0] rr_pc;
  logic [31:0] rr_instr;

  int n_total = 0;
  int n_pass  = 0;

  fetch_stage #(
    .XLEN      (32),
    .RESET_PC  (32'h0),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .data_stall      (data_stall),
    .control_stall   (control_stall),
    .redirect_valid  (redirect_valid),
    .redirect_taken  (redirect_taken),
    .redirect_target (redirect_target),
    .if_rs1          (if_rs1),
    .if_rs2          (if_rs2),
    .if_opcode       (if_opcode),
    .rr_valid        (rr_valid),
    .rr_pc           (rr_pc),
    .rr_instr        (rr_instr)
  );

  always #5 clk = ~clk;

  // Synchronous memory: address-as-instruction, data valid the next cycle.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rr(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, {31'b0, rr_valid}, 32'h1);
    check({tag, "_pc"}, rr_pc, pc);
    check({tag, "_instr"}, rr_instr, pc);
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_valid"}, {31'b0, rr_valid}, 32'h0);
    check({tag, "_instr"}, rr_instr, NOP);
  endtask

  initial begin
    rst_n = 1'b0; data_stall = 1'b0; control_stall = 1'b0;
    redirect_valid = 1'b0; redirect_taken = 1'b0; redirect_target = 32'h0;

    // Reset
    tick(); tick();
    check_bubble("rst");
    check("rst_rr_pc", rr_pc, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_opcode", {25'b0, if_opcode}, 32'h13);
    rst_n = 1'b1;
    #1;
    check("t1_req0", {31'b0, imem_req}, 32'h1);
    check("t1_addr0", imem_addr, 32'h0);

    // 1: streaming fetch, rr_pc 0 then 4
    tick(); tick();
    check("t1_slot_opc", {25'b0, if_opcode}, 32'h00);
    check_bubble("t1_prefill");
    tick(); check_rr("t1_rr0", 32'h0);
    tick(); check_rr("t1_rr4", 32'h4);
    check("t2_slot_opc", {25'b0, if_opcode}, 32'h08);

    // 2: data_stall for 3 cycles with slot pc=0x8
    data_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_bubble("t2_bubble");
      check("t2_pc_frozen", imem_addr, 32'h10);
      check("t2_no_req", {31'b0, imem_req}, 32'h0);
    end
    data_stall = 1'b0;
    tick(); check_rr("t2_rr8", 32'h8);
    tick(); check_rr("t2_rrC", 32'hC);
    tick(); check_rr("t2_rr10", 32'h10);

    // 3: control_stall pulse then taken redirect to 0x103
    control_stall = 1'b1;
    tick();
    check_bubble("t3_wait");
    check("t3_wait_req", {31'b0, imem_req}, 32'h0);
    control_stall = 1'b0;
    redirect_valid = 1'b1; redirect_taken = 1'b1; redirect_target = 32'h103;
    #1;
    check("t3_redir_req", {31'b0, imem_req}, 32'h0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("t3_req", {31'b0, imem_req}, 32'h1);
    check("t3_addr", imem_addr, 32'h100);
    check("t3_slot_empty_opc", {25'b0, if_opcode}, 32'h13);
    check_bubble("t3_flush0");
    tick(); check_bubble("t3_flush1");
    tick(); check_bubble("t3_flush2");
    tick(); check_rr("t3_rr100", 32'h100);

    // 4: control_stall then not-taken redirect
    control_stall = 1'b1;
    tick();
    check_bubble("t4_wait");
    control_stall = 1'b0;
    redirect_valid = 1'b1; redirect_taken = 1'b0; redirect_target = 32'h4000;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("t4_req", {31'b0, imem_req}, 32'h1);
    check("t4_addr", imem_addr, 32'h10C);
    check_bubble("t4_nt");
    tick(); check_rr("t4_rr104", 32'h104);
    tick(); check_rr("t4_rr108", 32'h108);
    tick(); check_rr("t4_rr10C", 32'h10C);

    // 5: taken redirect with a request in flight
    redirect_valid = 1'b1; redirect_taken = 1'b1; redirect_target = 32'h0108_8001;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("t5_addr", imem_addr, 32'h0108_8000);
    check("t5_req", {31'b0, imem_req}, 32'h1);
    check_bubble("t5_drop0");
    tick(); check_bubble("t5_drop1");
    tick(); check_bubble("t5_drop2");
    check("t5_rs1", {27'b0, if_rs1}, 32'h11);
    check("t5_rs2", {27'b0, if_rs2}, 32'h10);
    tick(); check_rr("t5_rr_tgt", 32'h0108_8000);

    // 6: reset while parked in WAIT_BR with a valid slot
    control_stall = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    check("t6_req_in_rst", {31'b0, imem_req}, 32'h0);
    tick();
    check_bubble("t6_rst");
    check("t6_rr_pc", rr_pc, 32'h0);
    check("t6_rs1", {27'b0, if_rs1}, 32'h0);
    check("t6_rs2", {27'b0, if_rs2}, 32'h0);
    check("t6_opcode", {25'b0, if_opcode}, 32'h13);
    rst_n = 1'b1; control_stall = 1'b0;
    #1;
    check("t6_req", {31'b0, imem_req}, 32'h1);
    check("t6_addr", imem_addr, 32'h0);
    tick(); tick(); tick();
    check_rr("t6_rr0", 32'h0);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_taken = 1'b1; redirect_target = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr_zero", imem_addr, 32'h0);
    check("wrap_req", {31'b0, imem_req}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
